shift_add_mult_ctrl: RTL and testbench

//   Sequential shift-and-add unsigned multiplier: one ksa adder, time-shared over BITS iterations.

---
 rtl/shift_add_mult_ctrl_pkg.sv | 13 +
 rtl/shift_add_mult_ctrl_ksa.sv | 43 ++++
 rtl/shift_add_mult_ctrl.sv | 92 +++++++++
 tb/tb_shift_add_mult_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// State codes are fixed; the spare code 2'd3 is treated as IDLE by the controller.
package shift_add_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_BITS = 8;

endpackage

// File: rtl/shift_add_mult_ctrl_ksa.sv
// Kogge-Stone adder, purely combinational: sum = a + b + cin (BITS wide, carry-out not produced).
// The prefix tree spans only the low BITS-1 bits, since only carries into bits 1..BITS-1 are needed.
module ksa #(
    parameter int BITS = 9
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum
);
    localparam int M      = BITS - 1;
    localparam int LEVELS = (M > 1) ? $clog2(M) : 0;

    logic [BITS-1:0] p_bit;
    logic [BITS-1:0] carry;

    assign p_bit = a ^ b;

    genvar l, i;
    for (l = 0; l <= LEVELS; l++) begin : lvl
        logic [M-1:0] g;
        logic [M-1:0] p;
        if (l == 0) begin : base
            assign g = a[M-1:0] & b[M-1:0];
            assign p = p_bit[M-1:0];
        end else begin : tree
            for (i = 0; i < M; i++) begin : col
                if (i >= (1 << (l - 1))) begin : merge
                    assign g[i] = lvl[l-1].g[i] | (lvl[l-1].p[i] & lvl[l-1].g[i-(1<<(l-1))]);
                    assign p[i] = lvl[l-1].p[i] & lvl[l-1].p[i-(1<<(l-1))];
                end else begin : pass
                    assign g[i] = lvl[l-1].g[i];
                    assign p[i] = lvl[l-1].p[i];
                end
            end
        end
    end

    // Group generate/propagate over [i:0] fold in cin to give the carry into bit i+1.
    assign carry = {lvl[LEVELS].g | (lvl[LEVELS].p & {M{cin}}), cin};
    assign sum   = p_bit ^ carry;

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one BITS+1 wide adder reused over BITS steps,
// operands latched on start, 2*BITS product presented with a one-cycle done pulse.
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BITS-1:0]   a,
    input  logic [BITS-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*BITS-1:0] product,
    output logic [1:0]        dbg_state
);
    localparam int CW = $clog2(BITS + 1);

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic [2*BITS-1:0]   product_q;
    logic [CW-1:0]       count_q;
    logic [BITS-1:0]     m_q;
    logic [2*BITS-1:0]   acc_q;
    logic [2*BITS-1:0]   acc_d;
    logic [BITS:0]       addend;
    logic [BITS:0]       sum;

    assign addend = acc_q[0] ? {1'b0, m_q} : '0;

    ksa #(.BITS(BITS + 1)) u_ksa (
        .a   ({1'b0, acc_q[2*BITS-1:BITS]}),
        .b   (addend),
        .cin (1'b0),
        .sum (sum)
    );

    // Shift {sum, LO} right by one: the adder carry lands in the ACC MSB.
    assign acc_d = {sum, acc_q[BITS-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            count_q   <= '0;
            m_q       <= '0;
            acc_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= a;
                        acc_q   <= {{BITS{1'b0}}, b};
                        count_q <= CW'(BITS);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        product_q <= acc_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: an 8-bit and a 5-bit instance, products checked against a
// scoreboard queue filled when each operation is started.
module tb_shift_add_mult_ctrl;

    logic        clk;
    logic        rst;
    logic        start8, start5;
    logic [7:0]  a8, b8;
    logic [4:0]  a5, b5;
    logic        busy8, done8, busy5, done5;
    logic [15:0] product8;
    logic [9:0]  product5;
    logic [1:0]  state8, state5;

    logic [15:0] exp_q[$];
    int checks;
    int failures;

    shift_add_mult_ctrl #(.BITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(product8), .dbg_state(state8)
    );

    shift_add_mult_ctrl #(.BITS(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5),
        .busy(busy5), .done(done5), .product(product5), .dbg_state(state5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0 || state8 !== 2'd0) begin
            failures++;
            $display("FAIL reset8 busy=%b done=%b product=%0d state=%0d expected 0/0/0/0",
                     busy8, done8, product8, state8);
        end
        checks++;
        if (busy5 !== 1'b0 || done5 !== 1'b0 || product5 !== 10'd0 || state5 !== 2'd0) begin
            failures++;
            $display("FAIL reset5 busy=%b done=%b product=%0d state=%0d expected 0/0/0/0",
                     busy5, done5, product5, state5);
        end
        rst = 1'b0;
    endtask

    task automatic run_op8(input logic [7:0] aa, input logic [7:0] bb);
        int cyc;
        logic [15:0] exp;
        logic [15:0] got;
        @(negedge clk);
        a8 = aa; b8 = bb; start8 = 1'b1;
        exp_q.push_back({8'd0, aa} * {8'd0, bb});
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        cyc = 1;
        while (done8 !== 1'b1 && cyc < 40) begin
            checks++;
            if (busy8 !== 1'b1) begin
                failures++;
                $display("FAIL run8_busy cycle=%0d got=%b expected=1", cyc, busy8);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 9) begin
            failures++;
            $display("FAIL run8_latency got=%0d expected=9", cyc);
        end
        exp = exp_q.pop_front();
        got = product8;
        checks++;
        if (product8 !== exp) begin
            failures++;
            $display("FAIL run8_product %0d*%0d got=%0d expected=%0d", aa, bb, product8, exp);
        end
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL run8_busy_in_done got=%b expected=1", busy8);
        end
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== got) begin
            failures++;
            $display("FAIL run8_after busy=%b done=%b product=%0d expected 0/0/%0d",
                     busy8, done8, product8, got);
        end
    endtask

    task automatic run_op5(input logic [4:0] aa, input logic [4:0] bb);
        int cyc;
        logic [15:0] exp;
        @(negedge clk);
        a5 = aa; b5 = bb; start5 = 1'b1;
        exp_q.push_back({11'd0, aa} * {11'd0, bb});
        @(negedge clk);
        start5 = 1'b0;
        a5 = 5'($urandom_range(0, 31));
        b5 = 5'($urandom_range(0, 31));
        cyc = 1;
        while (done5 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 6) begin
            failures++;
            $display("FAIL run5_latency got=%0d expected=6", cyc);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({6'd0, product5} !== exp) begin
            failures++;
            $display("FAIL run5_product %0d*%0d got=%0d expected=%0d", aa, bb, product5, exp);
        end
        @(negedge clk);
        checks++;
        if (busy5 !== 1'b0 || done5 !== 1'b0) begin
            failures++;
            $display("FAIL run5_after busy=%b done=%b expected 0/0", busy5, done5);
        end
    endtask

    task automatic test_basic();
        run_op8(8'd13, 8'd12);
    endtask

    task automatic test_carry();
        run_op8(8'd255, 8'd255);
        run_op8(8'd0, 8'd200);
    endtask

    task automatic test_ignore_start();
        int ndone;
        int dcyc;
        int busy_late;
        logic [15:0] got;
        logic [15:0] exp;
        ndone = 0; dcyc = 0; busy_late = 0; got = '0;
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd60; start8 = 1'b1;
        exp_q.push_back(16'd3000);
        @(negedge clk);
        start8 = 1'b0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (done8 === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    dcyc = cyc;
                    got  = product8;
                end
            end
            if (cyc >= 11 && busy8 !== 1'b0) busy_late++;
            if (cyc == 3) begin
                a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
            end
            if (cyc == 4) start8 = 1'b0;
            if (cyc == 9) start8 = 1'b1;
            if (cyc == 10) start8 = 1'b0;
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        checks++;
        if (ndone != 1 || dcyc != 9) begin
            failures++;
            $display("FAIL ignore_done count=%0d cycle=%0d expected 1 at 9", ndone, dcyc);
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL ignore_product got=%0d expected=%0d", got, exp);
        end
        checks++;
        if (busy_late != 0) begin
            failures++;
            $display("FAIL ignore_busy_after busy_cycles=%0d expected=0", busy_late);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int d0, d1;
        logic [15:0] p0, p1;
        logic [15:0] e0, e1;
        ndone = 0; d0 = 0; d1 = 0; p0 = '0; p1 = '0;
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
        exp_q.push_back(16'd63);
        exp_q.push_back(16'd300);
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd3;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (done8 === 1'b1) begin
                ndone++;
                if (ndone == 1) begin d0 = cyc; p0 = product8; end
                if (ndone == 2) begin d1 = cyc; p1 = product8; end
            end
            if (cyc == 11) start8 = 1'b0;
            @(negedge clk);
        end
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        checks++;
        if (ndone != 2 || d0 != 9 || d1 != 19) begin
            failures++;
            $display("FAIL b2b_timing count=%0d first=%0d second=%0d expected 2 at 9 and 19",
                     ndone, d0, d1);
        end
        checks++;
        if (p0 !== e0) begin
            failures++;
            $display("FAIL b2b_product0 got=%0d expected=%0d", p0, e0);
        end
        checks++;
        if (p1 !== e1) begin
            failures++;
            $display("FAIL b2b_product1 got=%0d expected=%0d", p1, e1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd201; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0 || state8 !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b product=%0d state=%0d expected 0/0/0/0",
                     busy8, done8, product8, state8);
        end
        run_op8(8'd3, 8'd5);
    endtask

    task automatic test_bits5();
        run_op5(5'd13, 5'd12);
        run_op5(5'd31, 5'd31);
        for (int k = 0; k < 6; k++) begin
            run_op5(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_random8();
        for (int k = 0; k < 8; k++) begin
            run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start5 = 1'b0; a5 = '0; b5 = '0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_bits5();
        test_random8();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
